// File: rtl/riscv_pkg.sv
// Shared execute-stage definitions: divider op codes, ALU control codes and the
// divider FSM state encoding.
package riscv_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // ALU control codes; ALU_DIV steers the execute result mux to the divider
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division iteration: shift in the next dividend bit, subtract
// the divisor if it fits, emit the quotient bit.
module div_step #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] rem,
    input  logic             din,
    input  logic [Width-1:0] divisor,
    output logic [Width-1:0] rem_next,
    output logic             qbit
);
    logic [Width:0] shifted;
    logic [Width:0] trial;

    // Full rem is shifted so the step stays exact for unsigned divisors >= 2^(Width-1)
    assign shifted  = {rem, din};
    assign trial    = shifted - {1'b0, divisor};
    assign qbit     = ~trial[Width];
    assign rem_next = qbit ? trial[Width-1:0] : shifted[Width-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with
// constant Width+2 cycle latency from the accepting edge.
module seq_divider
    import riscv_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Width-1:0] operand1,
    input  logic [Width-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] result,
    output logic             zero
);
    localparam int CW = $clog2(Width);

    div_state_t       state, state_nx;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [Width-1:0] a_r, b_r;
    logic [Width-1:0] rem, quo, dmag;
    logic             q_neg, r_neg;
    logic [Width-1:0] rem_nx;
    logic             qbit;
    logic             is_signed;
    logic [Width-1:0] q_fix, r_fix, fix_val;

    assign is_signed = ~op_r[0];

    div_step #(.Width(Width)) u_step (
        .rem      (rem),
        .din      (quo[Width-1]),
        .divisor  (dmag),
        .rem_next (rem_nx),
        .qbit     (qbit)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PREP;
            PREP:    state_nx = CALC;
            CALC:    if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = start ? PREP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sign fix-up and the two architecturally defined special cases
    always_comb begin
        q_fix = q_neg ? -quo : quo;
        r_fix = r_neg ? -rem : rem;
        if (b_r == '0) begin
            q_fix = '1;
            r_fix = a_r;
        end else if (is_signed && a_r == {1'b1, {(Width-1){1'b0}}} && b_r == '1) begin
            q_fix = a_r;
            r_fix = '0;
        end
        fix_val = op_r[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            rem    <= '0;
            quo    <= '0;
            dmag   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= operand1;
                        b_r  <= operand2;
                    end
                end
                PREP: begin
                    q_neg <= is_signed & (a_r[Width-1] ^ b_r[Width-1]);
                    r_neg <= is_signed & a_r[Width-1];
                    quo   <= (is_signed && a_r[Width-1]) ? -a_r : a_r;
                    dmag  <= (is_signed && b_r[Width-1]) ? -b_r : b_r;
                    rem   <= '0;
                    cnt   <= CW'(Width - 1);
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= {quo[Width-2:0], qbit};
                    cnt <= cnt - 1'b1;
                end
                FIX:     result <= fix_val;
                default: ;
            endcase
        end
    end

    assign busy = (state == PREP) || (state == CALC) || (state == FIX);
    assign done = (state == DONE);
    assign zero = (result == '0);

endmodule
